// File: rtl/seq_divider.sv
// Sequential restoring divider, signed or unsigned.
// Fixed latency of WIDTH+2 clock edges from the accepting edge to done,
// including divide-by-zero. Results are held until the next completion.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE_C       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LAST_ITER_C = WIDTH'(WIDTH - 1);

  // Two's-complement negation.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE_C;
  endfunction

  // Magnitude of an operand: negated only when signed and negative.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return negate(v);
    end else begin
      return v;
    end
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;

  logic [WIDTH-1:0] dvd_r;       // captured dividend
  logic [WIDTH-1:0] dvs_r;       // captured divisor
  logic             sgn_r;       // captured signed_op
  logic [WIDTH-1:0] qacc_r;      // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dmag_r;      // divisor magnitude
  logic [WIDTH:0]   rem_r;       // partial remainder
  logic [WIDTH-1:0] cnt_r;       // iteration counter
  logic             qneg_r;      // quotient must be negated
  logic             rneg_r;      // remainder must be negated

  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;

  logic [WIDTH+1:0] shifted_s;   // partial remainder shifted left with next dividend bit
  logic [WIDTH+1:0] diff_s;      // trial subtraction, sign in the top bit
  logic             dvs_zero_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  assign shifted_s  = {rem_r, qacc_r[WIDTH-1]};
  assign diff_s     = shifted_s - {2'b00, dmag_r};
  assign dvs_zero_s = (dvs_r == {WIDTH{1'b0}});

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: start is only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: state_nxt_s = ITER;
      ITER: begin
        if (cnt_r == LAST_ITER_C) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = ITER;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sign correction; a zero divisor overrides with all-ones / original dividend.
  always_comb begin
    q_fix_s = qacc_r;
    r_fix_s = rem_r[WIDTH-1:0];
    if (dvs_zero_s) begin
      q_fix_s = {WIDTH{1'b1}};
      r_fix_s = dvd_r;
    end else begin
      q_fix_s = qneg_r ? negate(qacc_r) : qacc_r;
      r_fix_s = rneg_r ? negate(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
    end
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      dvd_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      sgn_r       <= 1'b0;
      qacc_r      <= {WIDTH{1'b0}};
      dmag_r      <= {WIDTH{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      cnt_r       <= {WIDTH{1'b0}};
      qneg_r      <= 1'b0;
      rneg_r      <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            dvd_r  <= dividend;
            dvs_r  <= divisor;
            sgn_r  <= signed_op;
            busy_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        LOAD: begin
          qacc_r <= magnitude(dvd_r, sgn_r);
          dmag_r <= magnitude(dvs_r, sgn_r);
          rem_r  <= {(WIDTH+1){1'b0}};
          cnt_r  <= {WIDTH{1'b0}};
          qneg_r <= sgn_r & (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
          rneg_r <= sgn_r & dvd_r[WIDTH-1];
        end
        ITER: begin
          if (!diff_s[WIDTH+1]) begin
            rem_r  <= diff_s[WIDTH:0];
            qacc_r <= {qacc_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r  <= shifted_s[WIDTH:0];
            qacc_r <= {qacc_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r + ONE_C;
        end
        FIX: begin
          quotient_r  <= q_fix_s;
          remainder_r <= r_fix_s;
          dbz_r       <= dvs_zero_s;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=32): the driver pushes the
// hand-computed result and due edge; the monitor pops on every done.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  seq_divider #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   accept_edge;

  // Edge counter.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every done pulse with the oldest expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (edge %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", {32'd0, quotient}, {32'd0, e.q});
        check("remainder", {32'd0, remainder}, {32'd0, e.r});
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
        check("done_edge", 64'(cyc), 64'(e.due));
        check("busy_in_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  // Present one operation; returns at the negedge after the accepting edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz);
    exp_t e;
    @(negedge clock);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    @(posedge clock);
    #1;
    accept_edge = cyc;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.due = accept_edge + 34;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Wait until every expectation has been consumed, bounded.
  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clock);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  // Safety net in case the DUT stalls the bench.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Directed stimulus.
  initial begin
    clear     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (3) @(negedge clock);
    check("rst_quotient", {32'd0, quotient}, 64'd0);
    check("rst_remainder", {32'd0, remainder}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    clear = 1'b0;
    @(negedge clock);

    // 100/7 unsigned, with busy watched on edges 0..33.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    check("busy_edge0", {63'd0, busy}, 64'd1);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clock);
      check("busy_running", {63'd0, busy}, 64'd1);
    end
    wait_idle();
    repeat (5) @(negedge clock);
    check("hold_quotient", {32'd0, quotient}, 64'd14);
    check("hold_remainder", {32'd0, remainder}, 64'd2);

    // Signed / unsigned interpretation of the same bits.
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    wait_idle();
    issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
    wait_idle();

    // Divide by zero in both modes.
    issue(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    wait_idle();
    issue(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    wait_idle();

    // Most-negative by -1.
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    wait_idle();
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    wait_idle();

    // Ignored start at edge 10, then start held through the done cycle.
    issue(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
    repeat (9) @(negedge clock);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd77;
    divisor   = 32'd5;
    @(posedge clock);
    @(negedge clock);
    start     = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (24) @(negedge clock);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd33;
    @(posedge clock);
    #1;
    begin
      exp_t e;
      e.q   = 32'd30;
      e.r   = 32'd10;
      e.dz  = 1'b0;
      e.due = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    wait_idle();

    // Clear during iteration 15 aborts silently.
    issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    repeat (16) @(negedge clock);
    clear = 1'b1;
    #1;
    check("clr_busy", {63'd0, busy}, 64'd0);
    check("clr_quotient", {32'd0, quotient}, 64'd0);
    check("clr_remainder", {32'd0, remainder}, 64'd0);
    check("clr_done", {63'd0, done}, 64'd0);
    check("clr_dbz", {63'd0, div_by_zero}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    clear = 1'b0;
    repeat (40) @(negedge clock);
    check("clr_no_restart", {63'd0, busy}, 64'd0);
    issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    wait_idle();

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 4 to 64.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; port clock, input, 1 bit, rising-edge system clock.
REQ-003 Port clear, input, 1 bit, asynchronous active-high reset.
REQ-004 Port start, input, 1 bit, request to begin a division, sampled on the rising edge of clock.
REQ-005 Port signed_op, input, 1 bit; 1 selects two's-complement division, 0 selects unsigned; sampled together with start.
REQ-006 Port dividend, input, WIDTH bits, numerator; sampled with start.
REQ-007 Port divisor, input, WIDTH bits, denominator; sampled with start.
REQ-008 Port quotient, output, WIDTH bits, registered result.
REQ-009 Port remainder, output, WIDTH bits, registered result.
REQ-010 Port busy, output, 1 bit, high while an operation is in progress.
REQ-011 Port done, output, 1 bit, one-cycle pulse when quotient and remainder update.
REQ-012 Port div_by_zero, output, 1 bit, registered flag that updates with done.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, ITER and FIX.
- IDLE -> LOAD when start=1.
- LOAD -> ITER.
- ITER -> FIX after exactly WIDTH iterations.
- FIX -> IDLE.
REQ-014 start SHALL be accepted only in IDLE; start in any other state is ignored and does not disturb the operation in progress.
REQ-015 On acceptance, dividend, divisor and signed_op SHALL be captured into internal registers; later changes on these inputs have no effect on the operation.
REQ-016 LOAD SHALL form magnitudes: in signed mode a negative operand is two's-complement negated, otherwise it is used unchanged; the result signs are recorded (quotient sign = XOR of operand signs, remainder sign = dividend sign).
REQ-017 ITER SHALL perform one restoring shift-subtract step per cycle, using a WIDTH+1-bit partial remainder and a WIDTH-bit iteration counter.
REQ-018 FIX SHALL apply the sign corrections, write quotient, remainder and div_by_zero on the edge leaving FIX, and drive done=1 for exactly the following cycle.
REQ-019 Latency SHALL be fixed: counting the edge that accepts start as edge 0, outputs and done update at edge WIDTH+2, for every operand value including divide-by-zero.
REQ-020 busy SHALL be 1 from edge 0 until edge WIDTH+2, and 0 in the cycle in which done is high.
REQ-021 A start asserted in the cycle in which done is high SHALL be accepted, giving back-to-back operations.
REQ-022 The truncated quotient SHALL round toward zero; the remainder SHALL satisfy dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
REQ-023 A divisor of 0 SHALL produce quotient = all ones, remainder = the captured dividend unchanged and div_by_zero = 1, in both modes.
REQ-024 In signed mode, dividend = most-negative value with divisor = -1 SHALL produce quotient = most-negative value, remainder = 0 and div_by_zero = 0.
REQ-025 quotient, remainder and div_by_zero SHALL hold their values between completions.

Reset
REQ-026 clear=1 SHALL force, asynchronously:
- state to IDLE;
- quotient, remainder, busy, done and div_by_zero to 0;
- all internal registers and the counter to 0.
REQ-027 clear asserted mid-operation SHALL abort the operation with no done pulse; the first start accepted after clear deasserts SHALL complete normally.

Verification (WIDTH=32)
REQ-028 Unsigned: dividend 100, divisor 7, start -> quotient 14, remainder 2, done exactly at edge 34, busy high for edges 0-33.
REQ-029 Signed: dividend 0xFFFFFFF9 (-7), divisor 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); the same operands unsigned -> quotient 0x7FFFFFFC, remainder 1.
REQ-030 Divide by zero: dividend 0x1234, divisor 0 -> quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero 1, done at edge 34.
REQ-031 Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned with the same operands -> quotient 0, remainder 0x80000000.
REQ-032 Handshake: start pulsed at edge 10 of a running operation -> ignored, with the first result unchanged; start held high during the done cycle -> a second operation is accepted and completes 34 edges later.
REQ-033 Reset: clear pulsed at iteration 15 -> busy=0, all outputs 0, no done; next operation 50/5 -> quotient 10, remainder 0.
